pc_gen_way0: RTL

- Program-counter generator for way0; sits directly upstream of the way0 instruction fetch unit.
- Presents a fetch address plus valid, and advances when the fetch unit signals ready (instruction captured).
- Handles redirects from execute/branch resolution, front-end halt, and target misalignment.
- Tags each address with an epoch bit so downstream stages can discard in-flight instructions after a redirect.

---
 rtl/pc_gen_way0_if.sv | 38 +++
 rtl/pc_gen_way0.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/pc_gen_way0_if.sv
// Fetch-request bus between the way0 PC generator (master) and the way0 fetch unit (slave).
// Define PC_GEN_PERF_CNT_EN to add the fetch/redirect performance counter outputs.
interface pc_gen_way0_if;
    logic        ready_i;
    logic        halt_i;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;
    logic        valid_o;
    logic [31:0] pc_o;
    logic        epoch_o;
    logic        flush_o;
    logic        misalign_o;
    logic        halted_o;
`ifdef PC_GEN_PERF_CNT_EN
    logic [31:0] fetch_cnt_o;
    logic [31:0] redirect_cnt_o;

    modport master (
        input  ready_i, halt_i, redirect_valid_i, redirect_pc_i,
        output valid_o, pc_o, epoch_o, flush_o, misalign_o, halted_o,
        output fetch_cnt_o, redirect_cnt_o
    );
    modport slave (
        output ready_i, halt_i, redirect_valid_i, redirect_pc_i,
        input  valid_o, pc_o, epoch_o, flush_o, misalign_o, halted_o,
        input  fetch_cnt_o, redirect_cnt_o
    );
`else
    modport master (
        input  ready_i, halt_i, redirect_valid_i, redirect_pc_i,
        output valid_o, pc_o, epoch_o, flush_o, misalign_o, halted_o
    );
    modport slave (
        output ready_i, halt_i, redirect_valid_i, redirect_pc_i,
        input  valid_o, pc_o, epoch_o, flush_o, misalign_o, halted_o
    );
`endif
endinterface

// File: rtl/pc_gen_way0.sv
// Way0 program-counter generator: sequential fetch, redirects with epoch tagging, halt handling.
// Optional PC_GEN_PERF_CNT_EN adds free-running fetch and redirect counters.
module pc_gen_way0 #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] PC_STEP  = 32'd8
) (
    input  logic          clk,
    input  logic          reset_n,
    pc_gen_way0_if.master bus
);
    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        epoch_q, epoch_d;
    logic        flush_q, flush_d;
    logic        misalign_q, misalign_d;
    logic        halt_pend_q, halt_pend_d;
    logic        valid_q, valid_d;
    logic        halted_q, halted_d;
    logic        redirect_s;
    logic        advance_s;

    assign redirect_s = bus.redirect_valid_i;
    // ready_i only moves the address while a request is actually being presented
    assign advance_s  = (state_q == ST_RUN) && bus.ready_i && !redirect_s;

    // Next-state, next-PC and pulse computation
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        epoch_d     = epoch_q;
        flush_d     = 1'b0;
        misalign_d  = 1'b0;
        halt_pend_d = halt_pend_q;

        if (redirect_s) begin
            pc_d       = {bus.redirect_pc_i[31:2], 2'b00};
            epoch_d    = ~epoch_q;
            flush_d    = 1'b1;
            misalign_d = |bus.redirect_pc_i[1:0];
        end else if (advance_s) begin
            pc_d = pc_q + PC_STEP;
        end else begin
            pc_d = pc_q;
        end

        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                // A halt request only takes effect once the current address has been consumed
                if ((bus.ready_i || redirect_s) && (halt_pend_q || bus.halt_i)) begin
                    state_d = ST_HALT;
                end else begin
                    state_d     = ST_RUN;
                    halt_pend_d = halt_pend_q | bus.halt_i;
                end
            end
            ST_HALT: begin
                if (redirect_s) begin
                    state_d = ST_HALT;
                end else if (!bus.halt_i) begin
                    state_d     = ST_RUN;
                    halt_pend_d = 1'b0;
                end else begin
                    state_d = ST_HALT;
                end
            end
            default: begin
                state_d     = ST_BOOT;
                halt_pend_d = 1'b0;
            end
        endcase

        valid_d  = (state_d == ST_RUN);
        halted_d = (state_d == ST_HALT);
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_BOOT;
            pc_q        <= RESET_PC;
            epoch_q     <= 1'b0;
            flush_q     <= 1'b0;
            misalign_q  <= 1'b0;
            halt_pend_q <= 1'b0;
            valid_q     <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            epoch_q     <= epoch_d;
            flush_q     <= flush_d;
            misalign_q  <= misalign_d;
            halt_pend_q <= halt_pend_d;
            valid_q     <= valid_d;
            halted_q    <= halted_d;
        end
    end

    assign bus.valid_o    = valid_q;
    assign bus.pc_o       = pc_q;
    assign bus.epoch_o    = epoch_q;
    assign bus.flush_o    = flush_q;
    assign bus.misalign_o = misalign_q;
    assign bus.halted_o   = halted_q;

`ifdef PC_GEN_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] redirect_cnt_q, redirect_cnt_d;

    // Counter increments; both wrap silently
    always_comb begin
        if (advance_s && valid_q) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end else begin
            fetch_cnt_d = fetch_cnt_q;
        end
        if (redirect_s) begin
            redirect_cnt_d = redirect_cnt_q + 32'd1;
        end else begin
            redirect_cnt_d = redirect_cnt_q;
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_cnt_q    <= 32'd0;
            redirect_cnt_q <= 32'd0;
        end else begin
            fetch_cnt_q    <= fetch_cnt_d;
            redirect_cnt_q <= redirect_cnt_d;
        end
    end

    assign bus.fetch_cnt_o    = fetch_cnt_q;
    assign bus.redirect_cnt_o = redirect_cnt_q;
`endif
endmodule
